exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the 5-stage MIPS pipeline. Takes the raw fault flags from the decode and execute detectors (divide-by-zero in ID, out-of-range store address in EXE) and the external interrupt line, and prioritises them. It owns CP0 Status/Cause/EPC and drives the per-stage flushes, memory-write suppression and the PC redirect into the handler. It also sequences `eret` back to the saved EPC.

---
 rtl/exc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer for the 5-stage MIPS pipeline.
// Prioritises ADES (EXE), DIVZ (ID) and the external interrupt, owns CP0
// Status/Cause/EPC, and drives the flush/redirect sequence and eret return.
// Optional feature macro: EXC_CNT_EN adds a 16-bit saturating exception
// counter readable at CP0 address 22.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [4:0]  EXC_DIVZ     = 5'd12,
    parameter logic [4:0]  EXC_ADES     = 5'd5,
    parameter logic [4:0]  EXC_INT      = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_div0,
    input  logic [31:0] id_pc,
    input  logic        exe_ades,
    input  logic [31:0] exe_pc,
    input  logic        ext_irq,
    input  logic        eret_d,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        mem_we_block,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        exl
);

    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] A_CNT    = 5'd22;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIR,
        S_RET
    } state_t;

    state_t      state_q, state_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        ades_q, ades_d;   // cause class of the sequence in flight

    logic idle;
    logic take_ades, take_divz, take_int, take_exc, take_eret, sw_we;

    // Detection is only live in IDLE; everything seen in the other states
    // belongs to instructions that are being flushed.
    assign idle      = (state_q == S_IDLE);
    assign take_ades = idle & exe_ades;
    assign take_divz = idle & id_div0 & ~exe_ades;
    assign take_int  = idle & ext_irq & ie_q & ~exl_q & ~exe_ades & ~id_div0;
    assign take_exc  = take_ades | take_divz | take_int;
    assign take_eret = idle & eret_d & exl_q & ~take_exc;
    // A hardware update in the same cycle drops the software write.
    assign sw_we     = idle & cp0_we & ~take_exc;

    // State and CP0 register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            code_q  <= 5'd0;
            epc_q   <= 32'd0;
            ades_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            ades_q  <= ades_d;
        end
    end

    // Next state and sequencing outputs.
    always_comb begin
        state_d      = state_q;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        mem_we_block = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                // Kill the faulting store in its detection cycle.
                mem_we_block = exe_ades & ~rst;
                if (take_exc)       state_d = S_FLUSH;
                else if (take_eret) state_d = S_RET;
            end
            S_FLUSH: begin
                flush_d      = 1'b1;
                flush_e      = 1'b1;
                flush_m      = ades_q;   // the faulting store has moved to M
                mem_we_block = ades_q;
                state_d      = S_REDIR;
            end
            S_REDIR: begin
                flush_d     = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = HANDLER_ADDR;
                state_d     = S_IDLE;
            end
            S_RET: begin
                flush_d     = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = epc_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CP0 next values: exception entry, eret exit, then mtc0.
    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        code_d = code_q;
        epc_d  = epc_q;
        ades_d = ades_q;
        if (sw_we) begin
            unique case (cp0_addr)
                A_STATUS: begin
                    ie_d  = cp0_wdata[0];
                    exl_d = cp0_wdata[1];
                end
                A_CAUSE: code_d = cp0_wdata[6:2];
                A_EPC:   epc_d  = cp0_wdata;
                default: ;
            endcase
        end
        if (take_exc) begin
            exl_d  = 1'b1;
            ades_d = take_ades;
            if (take_ades)      code_d = EXC_ADES;
            else if (take_divz) code_d = EXC_DIVZ;
            else                code_d = EXC_INT;
            // A nested exception keeps the original return address.
            if (!exl_q) epc_d = take_ades ? exe_pc : id_pc;
        end
        if (state_q == S_RET) exl_d = 1'b0;
    end

`ifdef EXC_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of accepted exceptions; mtc0 to address 22 clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (sw_we && cp0_addr == A_CNT) cnt_d = 16'd0;
        if (take_exc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
`endif

    // mfc0 read mux; IP2 reflects the live interrupt line.
    always_comb begin
        cp0_rdata = 32'd0;
        unique case (cp0_addr)
            A_STATUS: cp0_rdata = {30'd0, exl_q, ie_q};
            A_CAUSE:  cp0_rdata = {21'd0, ext_irq, 3'd0, code_q, 2'd0};
            A_EPC:    cp0_rdata = epc_q;
`ifdef EXC_CNT_EN
            A_CNT:    cp0_rdata = {16'd0, cnt_q};
`else
            A_CNT:    cp0_rdata = 32'd0;
`endif
            default:  cp0_rdata = 32'd0;
        endcase
    end

    assign exl = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: each scenario pushes per-cycle stimulus and
// the expected outputs into paired queues, then drains them cycle by cycle.
module tb_exc_ctrl;

    localparam logic [31:0] H = 32'h0000_4180;
`ifdef EXC_CNT_EN
    localparam logic [31:0] CNT3 = 32'd3;
`else
    localparam logic [31:0] CNT3 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_div0 = 1'b0, exe_ades = 1'b0, ext_irq = 1'b0, eret_d = 1'b0, cp0_we = 1'b0;
    logic [31:0] id_pc = '0, exe_pc = '0, cp0_wdata = '0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_rdata, pc_target;
    logic        flush_d, flush_e, flush_m, mem_we_block, pc_redirect, exl;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .id_div0(id_div0), .id_pc(id_pc),
        .exe_ades(exe_ades), .exe_pc(exe_pc), .ext_irq(ext_irq), .eret_d(eret_d),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .mem_we_block(mem_we_block),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .exl(exl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, div0;
        logic [31:0] idpc;
        logic        ades;
        logic [31:0] expc;
        logic        irq, eret, we;
        logic [4:0]  addr;
        logic [31:0] wd;
    } stim_t;

    typedef struct packed {
        logic        fd, fe, fm, mwb, rd;
        logic [31:0] tgt;
        logic        x;
        logic [31:0] rdata;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    vecs = 0;
    int    miscmp = 0;

    function automatic stim_t S(logic r, logic dz, logic [31:0] ip, logic ad, logic [31:0] ep,
                                logic iq, logic er, logic w, logic [4:0] a, logic [31:0] d);
        S = '{r, dz, ip, ad, ep, iq, er, w, a, d};
    endfunction

    function automatic stim_t SR(logic [4:0] a);
        SR = S(0, 0, 0, 0, 0, 0, 0, 0, a, 0);
    endfunction

    function automatic exp_t E(logic fd, logic fe, logic fm, logic mwb, logic rd,
                               logic [31:0] tgt, logic x, logic [31:0] rdat);
        E = '{fd, fe, fm, mwb, rd, tgt, x, rdat};
    endfunction

    function automatic exp_t EI(logic x, logic [31:0] rdat);
        EI = E(0, 0, 0, 0, 0, 0, x, rdat);
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        rst = s.rst; id_div0 = s.div0; id_pc = s.idpc; exe_ades = s.ades; exe_pc = s.expc;
        ext_irq = s.irq; eret_d = s.eret; cp0_we = s.we; cp0_addr = s.addr; cp0_wdata = s.wd;
    endtask

    task automatic test_reset();
        stim_t s; exp_t e, got; int i = 0;
        push(SR(12), EI(0, 0));
        push(SR(13), EI(0, 0));
        push(SR(14), EI(0, 0));
        push(SR(22), EI(0, 0));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_divz();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0), EI(0, 0));
        push(SR(14), E(1, 1, 0, 0, 0, 0, 1, 'h40));
        push(SR(13), E(1, 0, 0, 0, 1, H, 1, 'h30));
        push(SR(12), EI(1, 2));
        push(S(0, 0, 0, 0, 0, 0, 0, 1, 12, 0), EI(1, 2));
        push(SR(12), EI(0, 0));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL divz[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_ades();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 0, 0, 1, 'h88, 0, 0, 0, 0, 0), E(0, 0, 0, 1, 0, 0, 0, 0));
        push(SR(14), E(1, 1, 1, 1, 0, 0, 1, 'h88));
        push(SR(13), E(1, 0, 0, 0, 1, H, 1, 'h14));
        push(SR(12), EI(1, 2));
        // nested div0 with eret in the same cycle: exception wins, EPC kept
        push(S(0, 1, 'h100, 0, 0, 0, 1, 0, 0, 0), EI(1, 0));
        push(SR(14), E(1, 1, 0, 0, 0, 0, 1, 'h88));
        push(SR(13), E(1, 0, 0, 0, 1, H, 1, 'h30));
        push(SR(12), EI(1, 2));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL ades[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_eret();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), EI(1, 0));
        push(SR(14), E(1, 0, 0, 0, 1, 'h88, 1, 'h88));
        push(SR(12), EI(0, 0));
        push(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), EI(0, 0));
        push(SR(12), EI(0, 0));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL eret[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_simul();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 1, 'h8C, 1, 'h88, 0, 0, 0, 0, 0), E(0, 0, 0, 1, 0, 0, 0, 0));
        push(SR(14), E(1, 1, 1, 1, 0, 0, 1, 'h88));
        push(SR(13), E(1, 0, 0, 0, 1, H, 1, 'h14));
        push(S(0, 0, 0, 0, 0, 0, 0, 1, 12, 0), EI(1, 2));
        push(SR(12), EI(0, 0));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL simul[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_int();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 0, 0, 0, 0, 1, 0, 0, 13, 0), EI(0, 'h414));          // IE=0: ignored, IP2 live
        push(S(0, 0, 0, 0, 0, 1, 0, 1, 12, 1), EI(0, 0));              // set IE
        push(S(0, 0, 'h200, 0, 0, 1, 0, 0, 12, 0), EI(0, 1));          // INT taken here
        push(S(0, 0, 0, 0, 0, 1, 0, 1, 14, 'hDEAD), E(1, 1, 0, 0, 0, 0, 1, 'h200)); // mtc0 ignored
        push(S(0, 0, 0, 0, 0, 1, 0, 0, 14, 0), E(1, 0, 0, 0, 1, H, 1, 'h200));
        push(S(0, 0, 0, 0, 0, 1, 0, 0, 13, 0), EI(1, 'h400));          // EXL masks INT
        push(S(0, 1, 'h300, 0, 0, 0, 0, 1, 12, 0), EI(1, 3));          // hw beats mtc0
        push(SR(12), E(1, 1, 0, 0, 0, 0, 1, 3));
        push(SR(14), E(1, 0, 0, 0, 1, H, 1, 'h200));
        push(SR(13), EI(1, 'h30));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL int[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_rst_mid();
        stim_t s; exp_t e, got; int i = 0;
        push(S(0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0), EI(1, 0));
        push(SR(0), E(1, 1, 0, 0, 0, 0, 1, 0));
        push(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), E(1, 0, 0, 0, 1, H, 1, 0));
        push(SR(12), EI(0, 0));
        push(SR(14), EI(0, 0));
        push(SR(13), EI(0, 0));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL rst_mid[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; exp_t e, got; int i = 0;
        for (int k = 0; k < 3; k++) begin
            push(S(0, 1, 32'h500 + 32'(4 * k), 0, 0, 0, 0, 0, 0, 0), EI(k != 0, 0));
            push(SR(0), E(1, 1, 0, 0, 0, 0, 1, 0));
            push(SR(0), E(1, 0, 0, 0, 1, H, 1, 0));
        end
        push(SR(22), EI(1, CNT3));
        push(S(0, 0, 0, 0, 0, 0, 0, 1, 22, 0), EI(1, CNT3));
        push(SR(22), EI(1, 0));
        push(SR(14), EI(1, 'h500));
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); apply(s); #1;
            got = {flush_d, flush_e, flush_m, mem_we_block, pc_redirect, pc_target, exl, cp0_rdata};
            vecs++;
            if (got !== e) begin miscmp++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got, e); end
            i++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_divz();
        test_ades();
        test_eret();
        test_simul();
        test_int();
        test_rst_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
